add_sub_seq: RTL

ADD_SUB_SEQ -- requirements
Module: add_sub_seq

---
 rtl/add_sub_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/add_sub_seq.sv
// Word-serial adder/subtractor: one WIDTH-bit ripple adder is reused across
// WORDS cycles, least-significant word first, behind a valid/ready handshake.

module param_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] s_o,
   output logic             c_o
);
   logic [WIDTH:0] c;

   assign c[0] = c_i;
   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      assign s_o[g]   = a_i[g] ^ b_i[g] ^ c[g];
      assign c[g+1]   = (a_i[g] & b_i[g]) | (c[g] & (a_i[g] ^ b_i[g]));
   end
   assign c_o = c[WIDTH];
endmodule

module add_sub_seq #(
   parameter int WIDTH = 4,
   parameter int WORDS = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic                   i_sub,
   input  logic [WIDTH*WORDS-1:0] i_op1,
   input  logic [WIDTH*WORDS-1:0] i_op2,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [WIDTH*WORDS-1:0] o_res,
   output logic                   o_carry_borrow
);
   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   if (WIDTH < 1 || WORDS < 1) begin : g_bad_param
      $fatal(1, "add_sub_seq: WIDTH (%0d) and WORDS (%0d) must both be >= 1", WIDTH, WORDS);
   end

   logic [1:0]                  state_q, state_d;
   logic [WORDS-1:0][WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
   logic                        sub_q, sub_d, carry_q, carry_d, cb_q, cb_d;
   logic [IDXW-1:0]             idx_q, idx_d;
   logic [WIDTH-1:0]            add_a, add_b, add_s;
   logic                        add_co;

   // Subtraction is op1 + ~op2 + 1; the +1 enters as the initial carry.
   assign add_a = op1_q[idx_q];
   assign add_b = op2_q[idx_q] ^ {WIDTH{sub_q}};

   param_adder #(.WIDTH(WIDTH)) u_adder (
      .a_i (add_a),
      .b_i (add_b),
      .c_i (carry_q),
      .s_o (add_s),
      .c_o (add_co)
   );

   always_comb begin
      state_d = state_q;
      op1_d   = op1_q;
      op2_d   = op2_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      res_d   = res_q;
      cb_d    = cb_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               op1_d   = i_op1;
               op2_d   = i_op2;
               sub_d   = i_sub;
               carry_d = i_sub;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[idx_q] = add_s;
            carry_d      = add_co;
            idx_d        = idx_q + 1'b1;
            if (idx_q == IDXW'(WORDS - 1)) begin
               cb_d    = add_co;
               state_d = DONE;
            end
         end
         DONE: begin
            if (i_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         op1_q   <= '0;
         op2_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         res_q   <= '0;
         cb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         cb_q    <= cb_d;
      end
   end

   assign o_ready        = (state_q == IDLE);
   assign o_valid        = (state_q == DONE);
   assign o_res          = res_q;
   assign o_carry_borrow = cb_q;
endmodule
